// File: rtl/uart_apb_txmux.sv
// uart_apb_txmux: shares one UART TX path between N_REQ byte producers with
// round-robin, packet-locked arbitration; sole APB master of the UART.

module uart_apb_txmux_lane (
  input  logic in_check,
  input  logic granted,
  input  logic credit_nz,
  output logic ready
);
  assign ready = in_check & granted & credit_nz;
endmodule

module uart_apb_txmux #(
  parameter int          N_REQ           = 2,
  parameter int          UART_FIFO_DEPTH = 2,
  parameter logic [15:0] ADDR_TX         = 16'h0004,
  parameter logic [15:0] ADDR_FSTAT      = 16'h0008,
  parameter int          LOCK_TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               apbm_psel,
  output logic               apbm_penable,
  output logic               apbm_pwrite,
  output logic [15:0]        apbm_paddr,
  output logic [31:0]        apbm_pwdata,
  input  logic [31:0]        apbm_prdata,
  input  logic               apbm_pready,
  input  logic               apbm_pslverr,
  output logic               err,
  input  logic               err_clr
);
  localparam int         GW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [8:0] DEPTH = 9'(UART_FIFO_DEPTH);
  localparam logic [7:0] LT    = 8'(LOCK_TIMEOUT);

  typedef enum logic [2:0] {IDLE, CHECK, POLL_S, POLL_A, WR_S, WR_A} state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [GW-1:0]      gidx_q, gidx_d;
  logic [GW-1:0]      last_grant_q, last_grant_d;
  logic [7:0]         credits_q, credits_d;
  logic [7:0]         idle_q, idle_d;
  logic               last_q, last_d;
  logic               psel_q, psel_d;
  logic               pen_q, pen_d;
  logic               pwrite_q, pwrite_d;
  logic [15:0]        paddr_q, paddr_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic               err_q, err_d;

  logic [GW-1:0]      nxt, arb_idx;
  logic               nxt_found;
  logic               xfer_done;
  logic [7:0]         idle_inc;
  logic [8:0]         lvl9;
  logic [7:0]         lvl_credit;
  logic [7:0]         cur_byte;
  logic               in_check;
  logic               unused_prdata;

  assign unused_prdata = ^apbm_prdata[31:8];
  assign xfer_done     = psel_q & pen_q & apbm_pready;
  assign idle_inc      = (idle_q == 8'hFF) ? idle_q : idle_q + 8'd1;
  assign lvl9          = {1'b0, apbm_prdata[7:0]};
  // Level at or above depth means no free slots; never go negative.
  assign lvl_credit    = (lvl9 >= DEPTH) ? 8'd0 : 8'(DEPTH - lvl9);
  assign cur_byte      = req_data[{gidx_q, 3'b000} +: 8];
  assign in_check      = (state_q == CHECK);

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    uart_apb_txmux_lane u_lane (
      .in_check (in_check),
      .granted  (grant_q[i]),
      .credit_nz(credits_q != 8'd0),
      .ready    (req_ready[i])
    );
  end

  // First valid requester strictly after last_grant, cyclic.
  always_comb begin
    nxt_found = 1'b0;
    nxt       = '0;
    arb_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      arb_idx = GW'((int'(last_grant_q) + k) % N_REQ);
      if (!nxt_found && req_valid[arb_idx]) begin
        nxt_found = 1'b1;
        nxt       = arb_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    last_grant_d = last_grant_q;
    credits_d    = credits_q;
    idle_d       = idle_q;
    last_d       = last_q;
    psel_d       = psel_q;
    pen_d        = pen_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    err_d        = err_q;
    if (err_clr)                  err_d = 1'b0;
    if (xfer_done & apbm_pslverr) err_d = 1'b1;
    case (state_q)
      IDLE: if (nxt_found) begin
        grant_d       = '0;
        grant_d[nxt]  = 1'b1;
        gidx_d        = nxt;
        last_grant_d  = nxt;
        idle_d        = 8'd0;
        state_d       = CHECK;
      end
      CHECK: begin
        if (credits_q == 8'd0) begin
          state_d  = POLL_S;
          psel_d   = 1'b1;
          pen_d    = 1'b0;
          pwrite_d = 1'b0;
          paddr_d  = ADDR_FSTAT;
        end else if (req_valid[gidx_q]) begin
          last_d    = req_last[gidx_q];
          credits_d = credits_q - 8'd1;
          idle_d    = 8'd0;
          state_d   = WR_S;
          psel_d    = 1'b1;
          pen_d     = 1'b0;
          pwrite_d  = 1'b1;
          paddr_d   = ADDR_TX;
          pwdata_d  = {24'h0, cur_byte};
        end else begin
          idle_d = idle_inc;
          if (LT != 8'd0 && idle_inc == LT) begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      POLL_S: begin
        pen_d   = 1'b1;
        state_d = POLL_A;
      end
      POLL_A: if (apbm_pready) begin
        psel_d    = 1'b0;
        pen_d     = 1'b0;
        // An errored read leaves credits at 0 so CHECK re-polls.
        credits_d = apbm_pslverr ? 8'd0 : lvl_credit;
        state_d   = CHECK;
      end
      WR_S: begin
        pen_d   = 1'b1;
        state_d = WR_A;
      end
      WR_A: if (apbm_pready) begin
        psel_d = 1'b0;
        pen_d  = 1'b0;
        if (last_q) begin
          state_d = IDLE;
          grant_d = '0;
        end else begin
          state_d = CHECK;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        psel_d  = 1'b0;
        pen_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      gidx_q       <= '0;
      last_grant_q <= GW'(N_REQ - 1);
      credits_q    <= 8'd0;
      idle_q       <= 8'd0;
      last_q       <= 1'b0;
      psel_q       <= 1'b0;
      pen_q        <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= 16'h0;
      pwdata_q     <= 32'h0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      gidx_q       <= gidx_d;
      last_grant_q <= last_grant_d;
      credits_q    <= credits_d;
      idle_q       <= idle_d;
      last_q       <= last_d;
      psel_q       <= psel_d;
      pen_q        <= pen_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      err_q        <= err_d;
    end
  end

  assign grant        = grant_q;
  assign apbm_psel    = psel_q;
  assign apbm_penable = pen_q;
  assign apbm_pwrite  = pwrite_q;
  assign apbm_paddr   = paddr_q;
  assign apbm_pwdata  = pwdata_q;
  assign err          = err_q;

endmodule

// File: tb/tb_uart_apb_txmux.sv
// Directed bench for uart_apb_txmux: APB slave model with scripted FSTAT
// levels and error injection, queue-fed requesters, bus and grant logs.

module tb_uart_apb_txmux;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid = '0, req_last = '0, req_ready, grant;
  logic [8*N-1:0] req_data = '0;
  logic           apbm_psel, apbm_penable, apbm_pwrite, apbm_pready, apbm_pslverr;
  logic [15:0]    apbm_paddr;
  logic [31:0]    apbm_pwdata, apbm_prdata;
  logic           err, err_clr = 1'b0;

  uart_apb_txmux #(.N_REQ(N), .UART_FIFO_DEPTH(2), .ADDR_TX(16'h0004),
                   .ADDR_FSTAT(16'h0008), .LOCK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant),
    .apbm_psel(apbm_psel), .apbm_penable(apbm_penable), .apbm_pwrite(apbm_pwrite),
    .apbm_paddr(apbm_paddr), .apbm_pwdata(apbm_pwdata), .apbm_prdata(apbm_prdata),
    .apbm_pready(apbm_pready), .apbm_pslverr(apbm_pslverr), .err(err), .err_clr(err_clr));

  int checks = 0, failures = 0;

  // APB slave model
  bit         slv_ready = 1'b1, stall_wr = 1'b0, rd_err_arm = 1'b0, wr_err_arm = 1'b0;
  logic [7:0] wr_err_byte = 8'h00;
  logic [7:0] lvl_tab [8];
  int         lvl_idx = 0;
  assign apbm_pready  = slv_ready && !(apbm_pwrite && stall_wr);
  assign apbm_prdata  = {24'h0, lvl_tab[lvl_idx]};
  assign apbm_pslverr = apbm_pwrite ? (wr_err_arm && apbm_pwdata[7:0] == wr_err_byte) : rd_err_arm;

  // bus log
  int          cyc = 0, log_n = 0, nrd = 0, nwr = 0;
  bit          lg_wr  [32];
  logic [15:0] lg_addr[32];
  logic [31:0] lg_data[32];
  int          lg_cyc [32];
  logic [7:0]  wlog   [32];
  logic        prev_psel = 1'b0, prev_pwrite = 1'b0;
  logic [15:0] prev_addr = '0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && apbm_psel && apbm_penable && apbm_pready) begin
      checks++;
      if (!(prev_psel && prev_addr == apbm_paddr && prev_pwrite == apbm_pwrite)) begin
        failures++;
        $display("FAIL apb_phase: addr=%h write=%b prev_psel=%b prev_addr=%h", apbm_paddr, apbm_pwrite, prev_psel, prev_addr);
      end
      if (log_n < 32) begin
        lg_wr[log_n] = apbm_pwrite; lg_addr[log_n] = apbm_paddr;
        lg_data[log_n] = apbm_pwdata; lg_cyc[log_n] = cyc;
        log_n++;
      end
      if (apbm_pwrite) begin
        if (nwr < 32) wlog[nwr] = apbm_pwdata[7:0];
        nwr++;
        if (apbm_pslverr) wr_err_arm = 1'b0;
      end else begin
        nrd++;
        rd_err_arm = 1'b0;
        if (lvl_idx < 7) lvl_idx++;
      end
    end
    prev_psel = apbm_psel; prev_addr = apbm_paddr; prev_pwrite = apbm_pwrite;
  end

  // grant log
  logic [N-1:0] prev_g = '0;
  logic [N-1:0] glog [16];
  int           gcyc [16];
  int           glog_n = 0;
  always @(negedge clk) begin
    if (grant !== prev_g) begin
      if (grant != '0 && glog_n < 16) begin
        glog[glog_n] = grant; gcyc[glog_n] = cyc; glog_n++;
      end
      prev_g = grant;
    end
  end

  // requesters: {last, byte} queues, advance on handshake
  logic [8:0] rq0[$], rq1[$];
  bit acc0 = 1'b0, acc1 = 1'b0;
  always @(posedge clk) begin
    if (rst_n && req_valid[0] && req_ready[0]) acc0 = 1'b1;
    if (rst_n && req_valid[1] && req_ready[1]) acc1 = 1'b1;
  end
  always @(negedge clk) begin
    if (acc0) begin if (rq0.size() > 0) rq0.delete(0); acc0 = 1'b0; end
    if (acc1) begin if (rq1.size() > 0) rq1.delete(0); acc1 = 1'b0; end
    if (rq0.size() > 0) begin req_valid[0] = 1'b1; req_data[7:0] = rq0[0][7:0]; req_last[0] = rq0[0][8]; end
    else begin req_valid[0] = 1'b0; req_last[0] = 1'b0; end
    if (rq1.size() > 0) begin req_valid[1] = 1'b1; req_data[15:8] = rq1[0][7:0]; req_last[1] = rq1[0][8]; end
    else begin req_valid[1] = 1'b0; req_last[1] = 1'b0; end
  end

  task automatic clear_logs();
    log_n = 0; nrd = 0; nwr = 0; glog_n = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rq0.delete(); rq1.delete(); acc0 = 1'b0; acc1 = 1'b0;
    req_valid = '0; req_last = '0;
    for (int i = 0; i < 8; i++) lvl_tab[i] = 8'd0;
    lvl_idx = 0; rd_err_arm = 1'b0; wr_err_arm = 1'b0;
    stall_wr = 1'b0; slv_ready = 1'b1; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
  endtask

  task automatic wait_wr(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (nwr >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) lvl_tab[i] = 8'd0;
    repeat (2) @(negedge clk);
    checks++; if (apbm_psel !== 1'b0)    begin failures++; $display("FAIL rst_psel: got %b want 0", apbm_psel); end
    checks++; if (apbm_penable !== 1'b0) begin failures++; $display("FAIL rst_penable: got %b want 0", apbm_penable); end
    checks++; if (apbm_pwrite !== 1'b0)  begin failures++; $display("FAIL rst_pwrite: got %b want 0", apbm_pwrite); end
    checks++; if (apbm_paddr !== 16'h0 || apbm_pwdata !== 32'h0) begin failures++; $display("FAIL rst_addr_data: got %h/%h want 0/0", apbm_paddr, apbm_pwdata); end
    checks++; if (grant !== 2'b00 || req_ready !== 2'b00) begin failures++; $display("FAIL rst_grant_ready: got %b/%b want 00/00", grant, req_ready); end
    checks++; if (err !== 1'b0)          begin failures++; $display("FAIL rst_err: got %b want 0", err); end
  endtask

  task automatic test_single();
    bit ok;
    bit         e_wr[5];
    logic [7:0] e_d [5];
    e_wr = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    e_d  = '{8'h00, 8'h41, 8'h42, 8'h00, 8'h43};
    do_reset();
    rq0.push_back({1'b0, 8'h41}); rq0.push_back({1'b0, 8'h42}); rq0.push_back({1'b1, 8'h43});
    wait_wr(3, 80, ok);
    repeat (4) @(negedge clk);
    checks++; if (!ok || log_n !== 5) begin failures++; $display("FAIL single_count: got %0d transfers want 5", log_n); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (lg_wr[i] !== e_wr[i] || lg_addr[i] !== (e_wr[i] ? 16'h0004 : 16'h0008) ||
          (e_wr[i] && lg_data[i] !== {24'h0, e_d[i]})) begin
        failures++;
        $display("FAIL single_bus[%0d]: got wr=%b addr=%h data=%h want wr=%b data=%h", i, lg_wr[i], lg_addr[i], lg_data[i], e_wr[i], e_d[i]);
      end
    end
    checks++; if (lg_cyc[2] - lg_cyc[1] !== 3) begin failures++; $display("FAIL single_rate: got %0d cycles want 3", lg_cyc[2] - lg_cyc[1]); end
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL single_release: got %b want 00", grant); end
    checks++; if (glog_n < 1 || glog[0] !== 2'b01) begin failures++; $display("FAIL single_first: got %b want 01", glog[0]); end
  endtask

  task automatic test_full_fifo();
    bit ok = 1'b0, early = 1'b0;
    do_reset();
    lvl_tab[0] = 8'd2; lvl_tab[1] = 8'd2; lvl_tab[2] = 8'd2; lvl_tab[3] = 8'd0;
    rq0.push_back({1'b1, 8'h5A});
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (nrd < 4 && req_ready !== 2'b00) early = 1'b1;
      if (nwr >= 1) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL full_write: got %0d writes want 1", nwr); end
    checks++; if (early) begin failures++; $display("FAIL full_ready: got ready=1 before credits want 0"); end
    checks++; if (nrd !== 4 || log_n !== 5) begin failures++; $display("FAIL full_reads: got %0d reads/%0d total want 4/5", nrd, log_n); end
    checks++; if (lg_wr[4] !== 1'b1 || lg_data[4] !== 32'h5A) begin failures++; $display("FAIL full_order: got wr=%b data=%h want 1/5a", lg_wr[4], lg_data[4]); end
  endtask

  task automatic test_two_req();
    bit ok;
    logic [7:0] e_d[6];
    e_d = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA2, 8'hA3};
    do_reset();
    rq0.push_back({1'b0, 8'hA0}); rq0.push_back({1'b1, 8'hA1});
    rq0.push_back({1'b0, 8'hA2}); rq0.push_back({1'b1, 8'hA3});
    rq1.push_back({1'b0, 8'hB0}); rq1.push_back({1'b1, 8'hB1});
    wait_wr(6, 150, ok);
    repeat (3) @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL two_count: got %0d writes want 6", nwr); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (wlog[i] !== e_d[i]) begin failures++; $display("FAIL two_order[%0d]: got %h want %h", i, wlog[i], e_d[i]); end
    end
    checks++;
    if (glog_n < 3 || glog[0] !== 2'b01 || glog[1] !== 2'b10 || glog[2] !== 2'b01) begin
      failures++; $display("FAIL two_grants: got n=%0d %b,%b,%b want 01,10,01", glog_n, glog[0], glog[1], glog[2]);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    rq0.push_back({1'b0, 8'hC0});
    rq1.push_back({1'b1, 8'hD0});
    wait_wr(2, 80, ok);
    repeat (3) @(negedge clk);
    checks++; if (!ok || wlog[0] !== 8'hC0 || wlog[1] !== 8'hD0) begin failures++; $display("FAIL to_order: got %h,%h want c0,d0", wlog[0], wlog[1]); end
    checks++; if (glog_n < 2 || glog[0] !== 2'b01 || glog[1] !== 2'b10) begin failures++; $display("FAIL to_grants: got %b,%b want 01,10", glog[0], glog[1]); end
    // write C0 completes, 4 idle CHECK cycles, IDLE, then grant to 1
    checks++; if (gcyc[1] - lg_cyc[1] !== 5) begin failures++; $display("FAIL to_delay: got %0d cycles want 5", gcyc[1] - lg_cyc[1]); end
  endtask

  task automatic test_pslverr();
    bit ok = 1'b0;
    do_reset();
    rd_err_arm = 1'b1; wr_err_arm = 1'b1; wr_err_byte = 8'h55;
    rq0.push_back({1'b0, 8'h55}); rq0.push_back({1'b1, 8'h56});
    wait_wr(2, 80, ok);
    repeat (2) @(negedge clk);
    checks++; if (!ok || nrd !== 2 || log_n !== 4) begin failures++; $display("FAIL perr_retry: got %0d reads/%0d total want 2/4", nrd, log_n); end
    checks++; if (wlog[0] !== 8'h55 || wlog[1] !== 8'h56) begin failures++; $display("FAIL perr_next: got %h,%h want 55,56", wlog[0], wlog[1]); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL perr_set: got %b want 1", err); end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL perr_clr: got %b want 0", err); end
    // err_clr held high across a failing write: set wins for that cycle
    err_clr = 1'b1; wr_err_arm = 1'b1; wr_err_byte = 8'h77;
    rq0.push_back({1'b1, 8'h77});
    wait_wr(3, 60, ok);
    checks++; if (!ok || err !== 1'b1) begin failures++; $display("FAIL perr_setwins: got %b want 1", err); end
    @(negedge clk);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL perr_clr2: got %b want 0", err); end
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok = 1'b0;
    do_reset();
    stall_wr = 1'b1;
    rq0.push_back({1'b1, 8'h11}); rq1.push_back({1'b1, 8'h22});
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (apbm_psel && apbm_penable && apbm_pwrite) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL rmid_reach: got no WR_A want WR_A"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (apbm_psel !== 1'b0 || apbm_penable !== 1'b0) begin failures++; $display("FAIL rmid_psel: got %b/%b want 0/0", apbm_psel, apbm_penable); end
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL rmid_grant: got %b want 00", grant); end
    rq0.push_back({1'b1, 8'h33});
    stall_wr = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
    wait_wr(2, 80, ok);
    repeat (2) @(negedge clk);
    checks++; if (!ok || glog_n < 2 || glog[0] !== 2'b01 || glog[1] !== 2'b10) begin failures++; $display("FAIL rmid_arb: got %b,%b want 01,10", glog[0], glog[1]); end
    checks++; if (wlog[0] !== 8'h33 || wlog[1] !== 8'h22) begin failures++; $display("FAIL rmid_data: got %h,%h want 33,22", wlog[0], wlog[1]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_fifo();
    test_two_req();
    test_timeout();
    test_pslverr();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
